wb_fade_master: RTL and testbench

//  Wishbone pipelined master that animates the PWM LED peripheral. It keeps one

---
 rtl/wb_fade_master_if.sv | 32 +++
 rtl/wb_fade_master.sv | 168 ++++++++++++++++
 tb/tb_wb_fade_master.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_fade_master_if.sv
// Wishbone pipelined bus bundle between the fade master and the PWM slave.
`timescale 1ns/1ps

interface wb_fade_master_if;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_stall_i;
    logic        wb_ack_i;

    modport master (
        output wb_cyc_o,
        output wb_stb_o,
        output wb_we_o,
        output wb_adr_o,
        output wb_dat_o,
        input  wb_stall_i,
        input  wb_ack_i
    );

    modport slave (
        input  wb_cyc_o,
        input  wb_stb_o,
        input  wb_we_o,
        input  wb_adr_o,
        input  wb_dat_o,
        output wb_stall_i,
        output wb_ack_i
    );
endinterface

// File: rtl/wb_fade_master.sv
// Wishbone pipelined master that animates the PWM LED peripheral: each channel
// holds a triangle-wave duty that steps on every prescaler tick, and each tick
// triggers a sweep that writes the current duties to PWM registers 0..CHANNELS-1.
`timescale 1ns/1ps

module wb_fade_master #(
    parameter int CHANNELS    = 3,
    parameter int BITS        = 5,
    parameter int TICK_DIV    = 65536,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    input  logic                    enable_i,
    wb_fade_master_if.master        wb,
    output logic                    busy_o,
    output logic                    timeout_o
);

    localparam int MAX  = (1 << BITS) - 1;
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PS_W = $clog2(TICK_DIV);
    localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [BITS-1:0] DUTY_MAX = BITS'(MAX);
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(TICK_DIV - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [CH_W-1:0] CH_LAST  = CH_W'(CHANNELS - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_REQUEST  = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK = 2'd2;
    localparam logic [1:0] ST_NEXT     = 2'd3;

    logic [1:0]      state;
    logic [CH_W-1:0] ch;
    logic [CH_W-1:0] ch_inc;
    logic [PS_W-1:0] prescaler;
    logic            tick;
    logic            pending;
    logic [TO_W-1:0] wait_cnt;
    logic [31:0]     adr_q;
    logic [31:0]     dat_q;

    logic [BITS-1:0] duty      [CHANNELS];
    logic            dir_down  [CHANNELS];
    logic [BITS-1:0] duty_next [CHANNELS];
    logic            dir_next  [CHANNELS];

    assign tick   = enable_i && (prescaler == PS_LAST);
    assign ch_inc = ch + CH_W'(1);

    // Free-running prescaler while enabled, parked at zero while disabled.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            prescaler <= '0;
        end else if (!enable_i || tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PS_W'(1);
        end
    end

    // Triangle step for every channel: bounce at the ends instead of wrapping.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            duty_next[c] = duty[c];
            dir_next[c]  = dir_down[c];
            if (tick) begin
                if (!dir_down[c] && duty[c] == DUTY_MAX) begin
                    dir_next[c]  = 1'b1;
                    duty_next[c] = DUTY_MAX - BITS'(1);
                end else if (dir_down[c] && duty[c] == '0) begin
                    dir_next[c]  = 1'b0;
                    duty_next[c] = BITS'(1);
                end else if (dir_down[c]) begin
                    duty_next[c] = duty[c] - BITS'(1);
                end else begin
                    duty_next[c] = duty[c] + BITS'(1);
                end
            end
        end
    end

    // Duty registers start spread evenly across the range so channels are out of phase.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int c = 0; c < CHANNELS; c++) begin
                duty[c]     <= BITS'((c * MAX) / CHANNELS);
                dir_down[c] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                duty[c]     <= duty_next[c];
                dir_down[c] <= dir_next[c];
            end
        end
    end

    // One-deep tick memory: a tick during a sweep requests exactly one more sweep.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            pending <= 1'b0;
        end else if (state == ST_IDLE) begin
            pending <= pending && tick;
        end else begin
            pending <= pending || tick;
        end
    end

    // Sweep sequencer; address/data are latched on entry to REQUEST using post-step duties.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state     <= ST_IDLE;
            ch        <= '0;
            wait_cnt  <= '0;
            timeout_o <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tick || pending) begin
                        state <= ST_REQUEST;
                        ch    <= '0;
                        adr_q <= '0;
                        dat_q <= 32'(duty_next[0]);
                    end
                end
                ST_REQUEST: begin
                    if (!wb.wb_stall_i) begin
                        state    <= ST_WAIT_ACK;
                        wait_cnt <= '0;
                    end
                end
                ST_WAIT_ACK: begin
                    if (wb.wb_ack_i) begin
                        state <= ST_NEXT;
                    end else if (wait_cnt == TO_LAST) begin
                        state     <= ST_NEXT;
                        timeout_o <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                ST_NEXT: begin
                    if (ch < CH_LAST) begin
                        state <= ST_REQUEST;
                        ch    <= ch_inc;
                        adr_q <= 32'(ch_inc);
                        dat_q <= 32'(duty_next[ch_inc]);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign wb.wb_cyc_o = (state == ST_REQUEST) || (state == ST_WAIT_ACK);
    assign wb.wb_stb_o = (state == ST_REQUEST);
    assign wb.wb_we_o  = 1'b1;
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign busy_o      = (state != ST_IDLE);

endmodule

// File: tb/tb_wb_fade_master.sv
// Self-checking bench for wb_fade_master: a reference duty model feeds a write
// scoreboard, a small reactive slave injects stalls and missing acks.
`timescale 1ns/1ps

module tb_wb_fade_master;

    localparam int CHANNELS    = 3;
    localparam int BITS        = 5;
    localparam int TICK_DIV    = 8;
    localparam int ACK_TIMEOUT = 15;
    localparam int MAX         = 31;

    typedef struct {
        int   stall_adr;
        int   stall_len;
        int   noack_adr;
        int   exp_busy;
        logic exp_timeout;
        int   exp_extra;
    } vec_t;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic busy;
    logic timeout;

    wb_fade_master_if wb();

    wb_fade_master #(
        .CHANNELS(CHANNELS),
        .BITS(BITS),
        .TICK_DIV(TICK_DIV),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_ni(rst_n),
        .enable_i(enable),
        .wb(wb.master),
        .busy_o(busy),
        .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    int  m_presc;
    int  m_duty [CHANNELS];
    bit  m_down [CHANNELS];

    wr_t sb_q[$];
    int  stall_adr = -1;
    int  stall_len = 0;
    int  noack_adr = -1;
    int  stall_cnt;
    bit  slave_stall;
    bit  accepted_prev;
    int  accepted_adr;
    int  next_adr;
    bit  prev_stb;
    int  writes = 0;
    int  max_ch0 = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference duty model: prescaler and triangle stepping, reset with the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_presc = 0;
            for (int c = 0; c < CHANNELS; c++) begin
                m_duty[c] = (c * MAX) / CHANNELS;
                m_down[c] = 1'b0;
            end
        end else if (!enable) begin
            m_presc = 0;
        end else if (m_presc == TICK_DIV - 1) begin
            m_presc = 0;
            for (int c = 0; c < CHANNELS; c++) begin
                if (!m_down[c]) begin
                    if (m_duty[c] == MAX) begin
                        m_down[c] = 1'b1;
                        m_duty[c] = m_duty[c] - 1;
                    end else begin
                        m_duty[c] = m_duty[c] + 1;
                    end
                end else begin
                    if (m_duty[c] == 0) begin
                        m_down[c] = 1'b0;
                        m_duty[c] = m_duty[c] + 1;
                    end else begin
                        m_duty[c] = m_duty[c] - 1;
                    end
                end
            end
        end else begin
            m_presc = m_presc + 1;
        end
    end

    // Slave responder plus scoreboard: push on each new request, pop on acceptance.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            next_adr      = 0;
            prev_stb      = 1'b0;
            accepted_prev = 1'b0;
            stall_cnt     = 0;
            wb.wb_stall_i = 1'b0;
            wb.wb_ack_i   = 1'b0;
        end else begin
            wb.wb_ack_i   = accepted_prev && (accepted_adr != noack_adr);
            accepted_prev = 1'b0;
            slave_stall   = 1'b0;
            if (wb.wb_stb_o) begin
                if (!prev_stb) begin
                    sb_q.push_back('{adr: 32'(next_adr), dat: 32'(m_duty[next_adr])});
                    next_adr  = (next_adr + 1) % CHANNELS;
                    stall_cnt = 0;
                end else if (sb_q.size() > 0) begin
                    checkOutput("held_adr", wb.wb_adr_o, sb_q[0].adr);
                    checkOutput("held_dat", wb.wb_dat_o, sb_q[0].dat);
                end
                if (int'(wb.wb_adr_o) == stall_adr && stall_cnt < stall_len) begin
                    slave_stall = 1'b1;
                    stall_cnt++;
                end
                if (!slave_stall) begin
                    if (sb_q.size() == 0) begin
                        checkOutput("expected_write_present", 32'd0, 32'd1);
                    end else begin
                        wr_t exp_wr;
                        exp_wr = sb_q.pop_front();
                        checkOutput("write_adr", wb.wb_adr_o, exp_wr.adr);
                        checkOutput("write_dat", wb.wb_dat_o, exp_wr.dat);
                    end
                    writes++;
                    accepted_prev = 1'b1;
                    accepted_adr  = int'(wb.wb_adr_o);
                    if (wb.wb_adr_o == 32'd0 && int'(wb.wb_dat_o) > max_ch0) begin
                        max_ch0 = int'(wb.wb_dat_o);
                    end
                end
            end
            wb.wb_stall_i = slave_stall;
            prev_stb      = wb.wb_stb_o;
        end
    end

    // One table row: enable from idle, measure the first sweep, then count the pending sweep.
    task automatic applyStimulus(input vec_t v, input int idx);
        int cycles;
        int busy_len;
        int writes_start;
        int extra;
        bit prev_busy;
        stall_adr = v.stall_adr;
        stall_len = v.stall_len;
        noack_adr = v.noack_adr;
        @(negedge clk);
        enable = 1'b1;
        cycles = 0;
        while (!busy && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput($sformatf("row%0d_tick_latency", idx), cycles, 8);
        checkOutput($sformatf("row%0d_first_adr", idx), wb.wb_adr_o, 32'd0);
        writes_start = writes;
        busy_len = 0;
        while (busy && busy_len < 100) begin
            @(negedge clk);
            busy_len++;
        end
        enable = 1'b0;
        checkOutput($sformatf("row%0d_busy_len", idx), busy_len, v.exp_busy);
        checkOutput($sformatf("row%0d_sweep_writes", idx), writes - writes_start, CHANNELS);
        checkOutput($sformatf("row%0d_timeout", idx), timeout, v.exp_timeout);
        extra = 0;
        prev_busy = busy;
        repeat (80) begin
            @(negedge clk);
            if (busy && !prev_busy) extra++;
            prev_busy = busy;
        end
        checkOutput($sformatf("row%0d_extra_sweeps", idx), extra, v.exp_extra);
        checkOutput($sformatf("row%0d_queue_drained", idx), sb_q.size(), 0);
    endtask

    initial begin
        vec_t vecs[5];
        int   cycles;
        int   busy_len;

        vecs[0] = '{stall_adr: -1, stall_len: 0, noack_adr: -1, exp_busy: 9,  exp_timeout: 1'b0, exp_extra: 1};
        vecs[1] = '{stall_adr: 1,  stall_len: 4, noack_adr: -1, exp_busy: 13, exp_timeout: 1'b0, exp_extra: 1};
        vecs[2] = '{stall_adr: 2,  stall_len: 1, noack_adr: -1, exp_busy: 10, exp_timeout: 1'b0, exp_extra: 1};
        vecs[3] = '{stall_adr: -1, stall_len: 0, noack_adr: 2,  exp_busy: 23, exp_timeout: 1'b1, exp_extra: 1};
        vecs[4] = '{stall_adr: -1, stall_len: 0, noack_adr: -1, exp_busy: 9,  exp_timeout: 1'b1, exp_extra: 1};

        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_cyc", wb.wb_cyc_o, 1'b0);
        checkOutput("reset_stb", wb.wb_stb_o, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_timeout", timeout, 1'b0);
        checkOutput("reset_adr", wb.wb_adr_o, 32'd0);
        checkOutput("reset_dat", wb.wb_dat_o, 32'd0);
        checkOutput("we_tied", wb.wb_we_o, 1'b1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Long free run across both bounces of the triangle.
        stall_adr = -1;
        noack_adr = -1;
        max_ch0   = 0;
        @(negedge clk);
        enable = 1'b1;
        repeat (64 * TICK_DIV + 40) @(negedge clk);
        enable = 1'b0;
        repeat (60) @(negedge clk);
        checkOutput("ch0_never_above_max", (max_ch0 <= MAX), 1'b1);
        checkOutput("ch0_reached_top_region", (max_ch0 >= MAX - 2), 1'b1);
        checkOutput("freerun_queue_drained", sb_q.size(), 0);

        // Reset while the master waits for an ack that never comes.
        noack_adr = 0;
        @(negedge clk);
        enable = 1'b1;
        cycles = 0;
        while (!(wb.wb_cyc_o && !wb.wb_stb_o) && cycles < 60) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("reached_wait_ack", (wb.wb_cyc_o && !wb.wb_stb_o), 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_cyc", wb.wb_cyc_o, 1'b0);
        checkOutput("async_reset_stb", wb.wb_stb_o, 1'b0);
        checkOutput("async_reset_busy", busy, 1'b0);
        noack_adr = -1;
        repeat (2) @(negedge clk);
        checkOutput("async_reset_adr", wb.wb_adr_o, 32'd0);
        checkOutput("async_reset_timeout", timeout, 1'b0);
        rst_n = 1'b1;
        cycles = 0;
        while (!busy && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("post_reset_tick_latency", cycles, 8);
        checkOutput("post_reset_dat0", wb.wb_dat_o, 32'd1);
        busy_len = 0;
        while (busy && busy_len < 100) begin
            @(negedge clk);
            busy_len++;
        end
        enable = 1'b0;
        checkOutput("post_reset_busy_len", busy_len, 9);
        repeat (40) @(negedge clk);
        checkOutput("post_reset_queue_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global time bound so a wedged run still reports.
    initial begin
        #500000;
        mismatched++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
